// File: rtl/nibble_add_sequencer_if.sv
// rtl/nibble_add_sequencer_if.sv - operand, adder-slice and result signals of the nibble add sequencer
interface nibble_add_sequencer_if #(
  parameter int WIDTH = 16
);
  // operand request channel
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;

  // shared external 4-bit adder slice
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;

  // result channel
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  // sequencer side
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub,
    output in_ready,
    output add_a, add_b, add_cin,
    input  add_sum, add_cout,
    output out_valid, out_sum, out_cout, out_ovf,
    input  out_ready
  );

  // requester / consumer / adder side
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub,
    input  in_ready,
    input  add_a, add_b, add_cin,
    output add_sum, add_cout,
    input  out_valid, out_sum, out_cout, out_ovf,
    output out_ready
  );
endinterface

// File: rtl/nibble_add_sequencer.sv
// rtl/nibble_add_sequencer.sv - multi-precision add/sub over one shared 4-bit adder, LSB nibble first
module nibble_add_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  nibble_add_sequencer_if.slave  bus
);

  localparam int WIDTH = 4 * NIBBLES;
  localparam int IDXW  = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // B already inverted for subtraction
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic             last_nib;
  logic             accept_in;
  logic             accept_out;

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDXW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  assign last_nib   = (idx_q == IDXW'(NIBBLES - 1));
  assign accept_in  = (state_q == S_IDLE) && bus.in_valid;
  assign accept_out = (state_q == S_DONE) && valid_q && bus.out_ready;

  // Next-state, datapath updates and result capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_in) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b ^ {WIDTH{bus.in_sub}};
          // subtraction forces the +1 of the two's complement; in_cin is ignored then
          carry_d = bus.in_sub | bus.in_cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDXW'(i)) begin
            sum_d[4*i +: 4] = bus.add_sum;
          end
        end
        carry_d = bus.add_cout;
        idx_d   = idx_q + IDXW'(1);
        if (last_nib) begin
          cout_d  = bus.add_cout;
          // signed overflow: operands agree in sign but the result does not
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (bus.add_sum[3] != a_q[WIDTH-1]);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // the result is published one cycle after the final nibble is written
        valid_d = 1'b1;
        if (accept_out) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // Adder slice is driven only while running; outputs stay zero otherwise.
  assign bus.add_a     = (state_q == S_RUN) ? nib_a   : 4'd0;
  assign bus.add_b     = (state_q == S_RUN) ? nib_b   : 4'd0;
  assign bus.add_cin   = (state_q == S_RUN) ? carry_q : 1'b0;

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = valid_q;

  // partial sums stay internal until the result is valid
  assign bus.out_sum   = valid_q ? sum_q  : '0;
  assign bus.out_cout  = valid_q ? cout_q : 1'b0;
  assign bus.out_ovf   = valid_q ? ovf_q  : 1'b0;

endmodule
